// File: rtl/pe_issue_seq_pkg.sv
// Shared types and constants for the PE issue sequencer.
package pe_issue_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Bit positions inside pe_ctl.
    localparam int PE_CTL_FIRST = 0;
    localparam int PE_CTL_LAST  = 1;

    // Width of the per-instruction iteration count; a count of 0 means 256.
    localparam int ITER_W = 8;

endpackage

// File: rtl/pe_issue_ctr.sv
// Per-instruction iteration counter. Holds the instruction length and the
// current iteration, and flags the first and last row of the instruction.
// A length of 0 wraps to 256 iterations because last compares against
// len-1 in ITER_W-bit arithmetic.
module pe_issue_ctr
    import pe_issue_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ITER_W-1:0] len_in,
    input  logic              step,
    output logic              first,
    output logic              last
);

    localparam logic [ITER_W-1:0] ITER_ONE = 1;

    logic [ITER_W-1:0] len;
    logic [ITER_W-1:0] iter;
    logic [ITER_W-1:0] len_m1;

    assign len_m1 = len - ITER_ONE;
    assign first  = (iter == '0);
    assign last   = (iter == len_m1);

    // Latch the length on load and restart counting; advance once per issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len  <= '0;
            iter <= '0;
        end else if (load) begin
            len  <= len_in;
            iter <= '0;
        end else if (step) begin
            iter <= iter + ITER_ONE;
        end
    end

endmodule

// File: rtl/pe_issue_seq.sv
// PE issue sequencer: walks the instruction list, issues neuron/weight SRAM
// row addresses one per cycle, presents valid/first/last to the PE aligned
// with the 1-cycle SRAM read data, and counts PE results to close the job.
module pe_issue_seq
    import pe_issue_seq_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INST_AW = 2,
    parameter int DATA_W  = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INST_AW:0]   inst_num,
    input  logic [ADDR_W-1:0]  neuron_base,
    input  logic [ADDR_W-1:0]  weight_base,
    output logic [INST_AW-1:0] inst_addr,
    input  logic [7:0]         inst_rdata,
    output logic [ADDR_W-1:0]  neuron_addr,
    output logic [ADDR_W-1:0]  weight_addr,
    input  logic [DATA_W-1:0]  neuron_rdata,
    input  logic [DATA_W-1:0]  weight_rdata,
    output logic [DATA_W-1:0]  pe_neuron,
    output logic [DATA_W-1:0]  pe_weight,
    output logic [1:0]         pe_ctl,
    output logic               pe_vld,
    input  logic               pe_vld_o,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [INST_AW:0]  IDX_ONE  = 1;

    state_t           state;
    logic [INST_AW:0] inst_num_q;
    logic [INST_AW:0] inst_idx;
    logic [INST_AW:0] inst_idx_nx;
    logic [INST_AW:0] res_cnt;
    logic             it_first;
    logic             it_last;

    // The instruction index register doubles as the instruction memory
    // address, so the read is already in flight during FETCH and the data
    // is ready to latch in LOAD.
    assign inst_addr   = inst_idx[INST_AW-1:0];
    assign inst_idx_nx = inst_idx + IDX_ONE;

    // SRAM data goes straight to the PE; pe_vld/pe_ctl are registered so
    // they line up with the row read one cycle after the address.
    assign pe_neuron = neuron_rdata;
    assign pe_weight = weight_rdata;

    pe_issue_ctr u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == LOAD),
        .len_in (inst_rdata),
        .step   (state == RUN),
        .first  (it_first),
        .last   (it_last)
    );

    // Job sequencing FSM with address and result counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            inst_num_q  <= '0;
            inst_idx    <= '0;
            res_cnt     <= '0;
            neuron_addr <= '0;
            weight_addr <= '0;
            pe_ctl      <= '0;
            pe_vld      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            pe_vld <= 1'b0;
            pe_ctl <= '0;
            done   <= 1'b0;

            // Results are counted in every active state, including the
            // cycle of the final issue.
            if (state != IDLE && pe_vld_o) begin
                res_cnt <= res_cnt + IDX_ONE;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        inst_num_q  <= inst_num;
                        neuron_addr <= neuron_base;
                        weight_addr <= weight_base;
                        inst_idx    <= '0;
                        res_cnt     <= '0;
                        busy        <= 1'b1;
                        state       <= (inst_num == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    pe_vld               <= 1'b1;
                    pe_ctl[PE_CTL_FIRST] <= it_first;
                    pe_ctl[PE_CTL_LAST]  <= it_last;
                    neuron_addr          <= neuron_addr + ADDR_ONE;
                    weight_addr          <= weight_addr + ADDR_ONE;
                    if (it_last) begin
                        inst_idx <= inst_idx_nx;
                        state    <= (inst_idx_nx == inst_num_q) ? DRAIN : FETCH;
                    end
                end
                DRAIN: begin
                    if (res_cnt == inst_num_q) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_issue_seq.sv
// Self-checking bench for pe_issue_seq: SRAM and PE models around the DUT,
// expected row streams built from the job description (lengths and bases).
module tb_pe_issue_seq;

    localparam int ADDR_W  = 16;
    localparam int INST_AW = 2;
    localparam int DATA_W  = 512;

    typedef struct packed {
        logic [15:0] n;
        logic [15:0] w;
        logic [1:0]  ctl;
    } row_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [INST_AW:0]   inst_num;
    logic [ADDR_W-1:0]  neuron_base;
    logic [ADDR_W-1:0]  weight_base;
    logic [INST_AW-1:0] inst_addr;
    logic [7:0]         inst_rdata;
    logic [ADDR_W-1:0]  neuron_addr;
    logic [ADDR_W-1:0]  weight_addr;
    logic [DATA_W-1:0]  neuron_rdata;
    logic [DATA_W-1:0]  weight_rdata;
    logic [DATA_W-1:0]  pe_neuron;
    logic [DATA_W-1:0]  pe_weight;
    logic [1:0]         pe_ctl;
    logic               pe_vld;
    logic               pe_vld_o;
    logic               busy;
    logic               done;

    logic [7:0] imem [4];
    logic [2:0] pe_pipe = 3'b000;
    logic       pe_auto;
    logic       pe_man;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   start_cyc;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   row_base;
    int   done_base;
    row_t rows[$];
    int   row_cyc[$];
    row_t exp_q[$];

    pe_issue_seq #(
        .ADDR_W  (ADDR_W),
        .INST_AW (INST_AW),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .inst_num     (inst_num),
        .neuron_base  (neuron_base),
        .weight_base  (weight_base),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .neuron_addr  (neuron_addr),
        .weight_addr  (weight_addr),
        .neuron_rdata (neuron_rdata),
        .weight_rdata (weight_rdata),
        .pe_neuron    (pe_neuron),
        .pe_weight    (pe_weight),
        .pe_ctl       (pe_ctl),
        .pe_vld       (pe_vld),
        .pe_vld_o     (pe_vld_o),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memories: data one cycle after the address; each row
    // carries its own address so the PE side can be checked for alignment.
    always @(posedge clk) begin
        inst_rdata   <= imem[inst_addr];
        neuron_rdata <= {{(DATA_W-ADDR_W){1'b0}}, neuron_addr};
        weight_rdata <= {{(DATA_W-ADDR_W){1'b1}}, weight_addr};
    end

    // PE model: one result a few cycles after each last row.
    always @(negedge clk) pe_pipe <= {pe_pipe[1:0], pe_auto & pe_vld & pe_ctl[1]};
    assign pe_vld_o = pe_pipe[2] | pe_man;

    // Monitor of what the PE sees and of done pulses.
    always @(negedge clk) begin
        if (pe_vld) begin
            rows.push_back({pe_neuron[15:0], pe_weight[15:0], pe_ctl});
            row_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Builds the expected rows from the job description, then starts it.
    task automatic start_job(input int n, input logic [15:0] nb, input logic [15:0] wb);
        int g;
        int len;
        row_t r;
        exp_q.delete();
        g = 0;
        for (int k = 0; k < n; k++) begin
            len = (imem[k] == 8'd0) ? 256 : int'(imem[k]);
            for (int j = 0; j < len; j++) begin
                r.n   = 16'(int'(nb) + g);
                r.w   = 16'(int'(wb) + g);
                r.ctl = {(j == len - 1), (j == 0)};
                exp_q.push_back(r);
                g++;
            end
        end
        row_base    = rows.size();
        done_base   = done_cnt;
        inst_num    = 3'(n);
        neuron_base = nb;
        weight_base = wb;
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic finish_job(input int limit);
        int waited;
        int nrows;
        int b0;
        waited = 0;
        while (done !== 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        chk("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_width", 64'(done), 64'd0);
        repeat (4) @(negedge clk);
        chk("done_once", 64'(done_cnt - done_base), 64'd1);
        nrows = rows.size() - row_base;
        chk("row_count", 64'(nrows), 64'(exp_q.size()));
        b0 = bad;
        for (int i = 0; i < nrows && i < exp_q.size(); i++) begin
            chk($sformatf("row%0d", i), 64'(rows[row_base+i]), 64'(exp_q[i]));
            if (i > 0)
                chk($sformatf("gap%0d", i), 64'(row_cyc[row_base+i] - row_cyc[row_base+i-1]),
                    exp_q[i].ctl[0] ? 64'd3 : 64'd1);
            if (bad != b0) break;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        inst_num    = '0;
        neuron_base = '0;
        weight_base = '0;
        pe_auto     = 1'b1;
        pe_man      = 1'b0;
        for (int k = 0; k < 4; k++) imem[k] = 8'd0;

        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pe_vld", 64'(pe_vld), 64'd0);
        chk("rst_pe_ctl", 64'(pe_ctl), 64'd0);
        chk("rst_naddr", 64'(neuron_addr), 64'd0);
        chk("rst_waddr", 64'(weight_addr), 64'd0);
        chk("rst_iaddr", 64'(inst_addr), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Four 35-iteration instructions: 140 contiguous addresses.
        for (int k = 0; k < 4; k++) imem[k] = 8'h23;
        start_job(4, 16'h0000, 16'h0000);
        finish_job(2000);
        chk("jobA_rows", 64'(rows.size() - row_base), 64'd140);

        // Single-row instructions: first and last on the same row.
        imem[0] = 8'd1;
        imem[1] = 8'd1;
        start_job(2, 16'h0040, 16'h8000);
        finish_job(200);

        // 256-iteration instruction crossing the address wrap.
        imem[0] = 8'd0;
        start_job(1, 16'hFFF0, 16'hFF00);
        finish_job(2000);

        // Empty job: done two cycles after start, no rows, no address walk.
        start_job(0, 16'h1111, 16'h2222);
        finish_job(20);
        chk("empty_done_latency", 64'(done_cyc - start_cyc), 64'd2);
        chk("empty_naddr", 64'(neuron_addr), 64'h1111);
        chk("empty_waddr", 64'(weight_addr), 64'h2222);

        // start mid-RUN with different job parameters is ignored.
        imem[0] = 8'h10;
        imem[1] = 8'h10;
        start_job(2, 16'h0100, 16'h0A00);
        repeat (6) @(negedge clk);
        inst_num    = 3'd1;
        neuron_base = 16'h7777;
        weight_base = 16'h1234;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_job(300);

        // Reset mid-RUN aborts at once with no done pulse.
        imem[0] = 8'h40;
        start_job(1, 16'h0200, 16'h0300);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_pe_vld", 64'(pe_vld), 64'd0);
        chk("abort_pe_ctl", 64'(pe_ctl), 64'd0);
        chk("abort_naddr", 64'(neuron_addr), 64'd0);
        chk("abort_waddr", 64'(weight_addr), 64'd0);
        chk("abort_iaddr", 64'(inst_addr), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - done_base), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        imem[0] = 8'd7;
        start_job(1, 16'h0300, 16'h0400);
        finish_job(100);

        // Results in IDLE are ignored; the job still waits for its own.
        pe_auto = 1'b0;
        repeat (3) begin
            @(negedge clk);
            pe_man = 1'b1;
            @(negedge clk);
            pe_man = 1'b0;
        end
        imem[0] = 8'd5;
        start_job(1, 16'h0500, 16'h0600);
        repeat (30) @(negedge clk);
        chk("idle_res_no_done", 64'(done_cnt - done_base), 64'd0);
        chk("idle_res_busy", 64'(busy), 64'd1);
        pe_man = 1'b1;
        @(negedge clk);
        pe_man = 1'b0;
        finish_job(20);
        pe_auto = 1'b1;

        // Random jobs.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++)
                imem[k] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
            start_job(int'($urandom_range(1, 4)), 16'($urandom), 16'($urandom));
            finish_job(3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_issue_seq.md
Name: pe_issue_seq

Overview:
- Sequencer directly upstream of parallel_pe.
- Walks an instruction list of per-instruction iteration counts and issues neuron/weight SRAM addresses.
- Drives the PE's vld_i/ctl[1:0] aligned with the 1-cycle-latency SRAM read data.
- Counts PE results (vld_o) and signals completion of a whole job.

Parameters:
ADDR_W, 16, neuron/weight SRAM address width
INST_AW, 2, instruction memory address width (depth 2^INST_AW)
DATA_W, 512, neuron/weight row width (32 x 16-bit lanes)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; ignored while busy
inst_num  in  INST_AW+1  number of instructions in job (0..2^INST_AW)
neuron_base  in  ADDR_W  first neuron row, latched on start
weight_base  in  ADDR_W  first weight row, latched on start
inst_addr  out  INST_AW  instruction memory read address
inst_rdata  in  8  iteration count, valid 1 cycle after inst_addr
neuron_addr  out  ADDR_W  neuron SRAM read address
weight_addr  out  ADDR_W  weight SRAM read address
neuron_rdata  in  DATA_W  neuron row, 1 cycle after address
weight_rdata  in  DATA_W  weight row, 1 cycle after address
pe_neuron  out  DATA_W  wire-through of neuron_rdata
pe_weight  out  DATA_W  wire-through of weight_rdata
pe_ctl  out  2  [0]=first iteration, [1]=last iteration
pe_vld  out  1  row valid to PE
pe_vld_o  in  1  result valid from PE
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset values: state=IDLE; all counters 0; inst_addr, neuron_addr, weight_addr, pe_ctl, pe_vld, busy, done = 0. Reset mid-job aborts immediately; no done pulse.
- FSM states:
  - IDLE: on start, latch inst_num, neuron_base, weight_base into neuron_addr/weight_addr; clear inst_idx and res_cnt; busy=1. Next state is DONE if inst_num==0, else FETCH.
  - FETCH: inst_addr=inst_idx; next LOAD.
  - LOAD: len<=inst_rdata; iter<=0; next RUN.
  - RUN: one issue per cycle. Issue row = (neuron_addr, weight_addr) with first=(iter==0), last=(iter==len-1, 8-bit wrap).
    - Addresses increment by 1 after each issue, wrapping modulo 2^ADDR_W.
    - On last: inst_idx++. If inst_idx+1==inst_num go to DRAIN, else go to FETCH.
  - DRAIN: wait until res_cnt==inst_num; then DONE.
  - DONE: done=1 for one cycle; busy=0 from next cycle; next IDLE.
- len=0 means 256 iterations; last fires at iter==255.
- pe_vld/pe_ctl are registered copies of the issue strobe/first/last. They align with rdata one cycle after the address.
  - pe_neuron/pe_weight are combinational pass-through; total latency from address to PE input is 1 cycle.
  - len==1 gives pe_ctl=2'b11 on a single row.
- Two idle pe_vld cycles (FETCH, LOAD) between instructions; the PE tolerates vld gaps.
- Neuron/weight addresses are continuous across instructions; there is no re-base per instruction.
- res_cnt increments on pe_vld_o in any non-IDLE state. pe_vld_o in IDLE is ignored.
  - A result arriving in the same cycle as the last issue still counts.
- start while busy is ignored. start in the same cycle as done (DONE state) is also ignored.
- Address outputs hold their last value when not issuing. SRAM reads while idle are harmless.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, FETCH, LOAD, RUN, DRAIN, DONE.
  - Constants PE_CTL_FIRST=0 and PE_CTL_LAST=1.
  - ITER_W=8.
- One natural sub-module: pe_issue_ctr. It is the per-instruction iteration counter; it produces first/last from len and iter, including the 0→256 rule.
- FSM, address counters and result counter stay in the top.

Test Plan:
- inst={0x23,0x23,0x23,0x23}, inst_num=4, bases 0: exactly 140 pe_vld rows with addresses 0..139.
  - pe_ctl=01 at rows 0/35/70/105; pe_ctl=10 at rows 34/69/104/139.
  - Model PE returning 4 vld_o pulses produces one done after the 4th; busy low the next cycle.
- inst={1,1}, inst_num=2: two rows, each pe_ctl=11, separated by exactly 2 non-valid cycles.
- inst={0}, inst_num=1, neuron_base=0xFFF0: 256 rows; addresses wrap 0xFFFF→0x0000; last=1 only on row 256.
- inst_num=0: start gives done 2 cycles later, no pe_vld, no address change.
- start re-asserted mid-RUN: ignored, with no change to addresses or count. rst_n dropped mid-RUN: all outputs 0 asynchronously, no done.
  - A new start after reset completes normally.
- pe_vld_o pulses while IDLE: res_cnt stays 0; a subsequent 1-instruction job still needs exactly 1 result before done.
